// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch types. The per-entry illegal flag only exists when
// FETCH_QUEUE_ILLEGAL_CHECK_EN is defined.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
`ifdef FETCH_QUEUE_ILLEGAL_CHECK_EN
    logic            illegal;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: circular buffer with flush, registered-only outputs.
// Optional per-entry illegal-encoding flag under FETCH_QUEUE_ILLEGAL_CHECK_EN.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2  // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  logic push;
  logic pop;

  // Handshakes depend only on occupancy, never on same-cycle out_ready or flush.
  assign in_ready  = (count_q < FullCount);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = in_pc;
    wr_entry.instr = in_instr;
`ifdef FETCH_QUEUE_ILLEGAL_CHECK_EN
    // Anything not ending in 2'b11 is a compressed or reserved encoding.
    wr_entry.illegal = (in_instr[1:0] != 2'b11);
`endif
  end

  // Storage is not reset; head/tail/count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    head_entry = mem_q[head_q];
    out_pc     = out_valid ? head_entry.pc : '0;
    out_instr  = out_valid ? head_entry.instr : NOP_INSTR;
`ifdef FETCH_QUEUE_ILLEGAL_CHECK_EN
    out_illegal = out_valid && head_entry.illegal;
`else
    out_illegal = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_illegal(out_illegal),
    .count      (count)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_illegal();
`ifdef FETCH_QUEUE_ILLEGAL_CHECK_EN
    return (mq.size() != 0) && (mq[0].instr[1:0] != 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_model(input string tag);
    logic        v;
    logic [63:0] epc;
    logic [31:0] ein;
    v   = (mq.size() != 0);
    epc = v ? mq[0].pc : 64'h0;
    ein = v ? mq[0].instr : 32'h0000_0013;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".out_pc"}, out_pc, epc);
    check({tag, ".out_instr"}, 64'(out_instr), 64'(ein));
    check({tag, ".out_illegal"}, 64'(out_illegal), 64'(exp_illegal()));
    check({tag, ".count"}, 64'(count), 64'(mq.size()));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
  endtask

  // One clock: drive at negedge, predict, check outputs #1 after the edge.
  task automatic step(input string tag, input logic rst, input logic iv,
                      input logic [63:0] pc, input logic [31:0] instr,
                      input logic fl, input logic ordy);
    logic m_push, m_pop;
    ent_t e;
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr;
    flush     = fl;
    out_ready = ordy;
    #1;
    check({tag, ".pre_in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
    m_push = iv && (mq.size() < DEPTH) && !fl;
    m_pop  = (mq.size() != 0) && ordy && !fl;
    @(posedge clk);
    #1;
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        e.pc    = pc;
        e.instr = instr;
        mq.push_back(e);
      end
    end
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset state
    step("rst", 1, 0, 64'h0, 32'h0, 0, 0);
    check("rst.in_ready_one", 64'(in_ready), 64'd1);
    check("rst.out_instr_nop", 64'(out_instr), 64'h13);

    // Single push becomes visible after the edge
    step("push1", 0, 1, 64'h0, 32'h0050_0093, 0, 0);
    check("push1.pc_const", out_pc, 64'h0);
    check("push1.instr_const", 64'(out_instr), 64'h0050_0093);

    // Fill and overflow attempt, then drain in order
    step("rst2", 1, 0, 64'h0, 32'h0, 0, 0);
    step("fill0", 0, 1, 64'h0, 32'h0000_0013, 0, 0);
    step("fill4", 0, 1, 64'h4, 32'h0000_0013, 0, 0);
    step("fill8", 0, 1, 64'h8, 32'h0000_0013, 0, 0);
    check("full.count_two", 64'(count), 64'd2);
    check("full.in_ready_zero", 64'(in_ready), 64'd0);
    step("drain0", 0, 0, 64'h0, 32'h0, 0, 1);
    check("drain0.pc_const", out_pc, 64'h4);
    step("drain1", 0, 0, 64'h0, 32'h0, 0, 1);
    step("drain_empty", 0, 0, 64'h0, 32'h0, 0, 1);

    // Simultaneous push and pop at count=1, across pointer wrap
    step("one", 0, 1, 64'h0, 32'h0000_0013, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("pushpop", 0, 1, 64'h10 + 64'(4 * i), 32'h0000_0013, 0, 1);
      check("pushpop.pc_const", out_pc, 64'h10 + 64'(4 * i));
      check("pushpop.count_one", 64'(count), 64'd1);
    end

    // Flush dominates a concurrent push
    step("f_fill", 0, 1, 64'h20, 32'h0000_0013, 0, 0);
    step("flush", 0, 1, 64'h30, 32'h0000_0013, 1, 1);
    check("flush.count_zero", 64'(count), 64'd0);
    step("after_flush", 0, 1, 64'h40, 32'h0000_0013, 0, 0);
    check("after_flush.pc_const", out_pc, 64'h40);

    // Illegal flag
    step("ill_rst", 1, 0, 64'h0, 32'h0, 0, 0);
    step("ill_push0", 0, 1, 64'h100, 32'h0000_0000, 0, 0);
    step("ill_push13", 0, 1, 64'h104, 32'h0000_0013, 0, 1);

    // Reset overrides flush with a full queue
    step("r_fill", 0, 1, 64'h200, 32'h0000_0013, 0, 0);
    check("r_fill.count_two", 64'(count), 64'd2);
    step("rst_flush", 1, 1, 64'h300, 32'h0000_0013, 1, 1);
    check("rst_flush.out_pc_zero", out_pc, 64'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1) == 1),
           {32'($urandom), 32'($urandom)},
           32'($urandom),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 2, number of queue entries; power of two, >= 2.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  fetch stage presents an entry.
REQ-005 Port: in_ready  output  1  queue accepts an entry this cycle.
REQ-006 Port: in_pc  input  64  PC of the fetched instruction.
REQ-007 Port: in_instr  input  32  fetched instruction word.
REQ-008 Port: flush  input  1  branch taken / redirect; discard all contents.
REQ-009 Port: out_valid  output  1  head entry available to decode.
REQ-010 Port: out_ready  input  1  decode consumes head this cycle.
REQ-011 Port: out_pc  output  64  PC of head entry.
REQ-012 Port: out_instr  output  32  instruction of head entry.
REQ-013 Port: out_illegal  output  1  head instruction flagged illegal (see Configuration).
REQ-014 Port: count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Push occurs on a rising edge when in_valid && in_ready && !flush; entry written at tail, tail pointer increments.
REQ-016 Pop occurs on a rising edge when out_valid && out_ready && !flush; head pointer increments.
REQ-017 in_ready = (count < DEPTH); no combinational dependence on out_ready or flush.
REQ-018 out_valid = (count != 0); out_pc/out_instr driven combinationally from the head storage entry.
REQ-019 When out_valid=0, out_pc shall be 64'h0 and out_instr shall be 32'h00000013 (NOP).
REQ-020 Latency: an entry pushed at edge N is visible on out_* after edge N; no same-cycle bypass from in_* to out_*.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-022 Full (count=DEPTH): in_ready=0; a pop on that edge does not enable a push on the same edge.
REQ-023 Empty: out_ready ignored; no pointer movement from pop.
REQ-024 Pointers are clog2(DEPTH) bits and wrap modulo DEPTH with no gaps or lost entries.
REQ-025 Flush dominates: at the edge where flush=1, count, head and tail go to 0, concurrent push and pop are discarded; out_valid=0 for the following cycle.
REQ-026 While out_valid=1 and out_ready=0, out_pc/out_instr/out_illegal shall remain stable.

Reset
REQ-027 At a rising edge with reset=1: count=0, head=0, tail=0; therefore out_valid=0, in_ready=1, out_pc=0, out_instr=32'h00000013, out_illegal=0.
REQ-028 Reset overrides flush, push and pop in the same cycle; storage contents need not be cleared.

Configuration
REQ-029 Macro FETCH_QUEUE_ILLEGAL_CHECK_EN: when defined, out_illegal = out_valid && (out_instr[1:0] != 2'b11), with the flag computed at push and stored per entry.
REQ-030 Without FETCH_QUEUE_ILLEGAL_CHECK_EN, out_illegal is constant 0 and no per-entry flag storage exists.

Structure
REQ-031 Shared package riscv_pkg holds XLEN=64, ILEN=32, NOP_INSTR=32'h00000013 and typedef fetch_entry_t {pc, instr, illegal}.
REQ-032 Single module; storage is an internal array of fetch_entry_t; no sub-module.

Verification
REQ-033 Reset, then push PC=0x0/instr=0x00500093 with out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x00500093, count=1.
REQ-034 DEPTH=2, push 0x0, 0x4, 0x8 back-to-back with out_ready=0 -> count=2, in_ready=0, 0x8 not accepted; then out_ready=1 -> outputs 0x0, then 0x4, in order.
REQ-035 count=1, simultaneous push 0x10 and pop -> count stays 1, out_pc=0x10 next cycle; repeat 5 times -> pointer wrap, no loss or duplication.
REQ-036 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_instr=0x00000013; next push 0x40 appears alone at head.
REQ-037 With FETCH_QUEUE_ILLEGAL_CHECK_EN, push instr=0x00000000 -> out_illegal=1; push 0x00000013 -> out_illegal=0; without macro -> out_illegal=0 for both.
REQ-038 reset=1 asserted with count=2 and flush=1 -> next cycle all outputs at REQ-027 values.
